entity_draw_sequencer: RTL and testbench

Frame-level consumer of the per-entity position/sprite outputs of the game logic (three `x`/`y`/`spawn`/`adr` slots). On each frame request it snapshots all slots, walks the sprite ROM of every spawned entity, offsets each ROM point by the entity position and streams absolute beam points to the vector DAC stage over a valid/ready handshake. It sits between game logic and the vector output driver, all on the 100 MHz domain.

---
 rtl/vector_pkg.sv | 13 +
 rtl/vec_point_sat.sv | 15 +
 rtl/entity_draw_sequencer.sv | 165 ++++++++++++++++
 tb/tb_entity_draw_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// vector_pkg: shared types for the vector drawing path.
// Contents: entity slot count, the sprite ROM word layout and the draw sequencer FSM states.
package vector_pkg;
    localparam int ENTITY_COUNT   = 3;
    localparam int SPRITE_COORD_W = 8;
    typedef struct packed {
        logic                      last;
        logic                      beam;
        logic [SPRITE_COORD_W-1:0] yoff;
        logic [SPRITE_COORD_W-1:0] xoff;
    } sprite_word_t;
    typedef enum logic [2:0] {IDLE, SELECT, ADDR, DATA, EMIT, DONE} draw_state_t;
endpackage

// File: rtl/vec_point_sat.sv
// vec_point_sat: saturating unsigned add of a base coordinate and an offset for one axis.
// Ports: base, off (W-bit unsigned) in; sum (W-bit, clamped to all-ones on carry) out.
module vec_point_sat
    import vector_pkg::*;
#(
    parameter int W = SPRITE_COORD_W
) (
    input  logic [W-1:0] base,
    input  logic [W-1:0] off,
    output logic [W-1:0] sum
);
    logic [W:0] full;
    assign full = {1'b0, base} + {1'b0, off};
    assign sum  = full[W] ? '1 : full[W-1:0];
endmodule

// File: rtl/entity_draw_sequencer.sv
// entity_draw_sequencer: per frame, snapshots the entity slots and streams each spawned sprite as absolute beam points.
// Ports: clk, rst (sync, active-low); frame_start; x_ent/y_ent/spawn_ent/adr_ent slot inputs;
//        rom_adr out / rom_data in (one-cycle latency sprite ROM); x_out/y_out/beam_en/out_valid with out_ready;
//        busy, frame_done, frame_overrun status.
// Build option: ENTITY_BLANK_MOVE_EN emits a beam-off move to each entity's base position before its sprite.
module entity_draw_sequencer
    import vector_pkg::*;
#(
    parameter int OUT_WIDTH    = 8,
    parameter int ADDRESSWIDTH = 16,
    parameter int MAX_POINTS   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic [OUT_WIDTH-1:0]     x_ent [ENTITY_COUNT],
    input  logic [OUT_WIDTH-1:0]     y_ent [ENTITY_COUNT],
    input  logic [ENTITY_COUNT-1:0]  spawn_ent,
    input  logic [ADDRESSWIDTH-1:0]  adr_ent [ENTITY_COUNT],
    output logic [ADDRESSWIDTH-1:0]  rom_adr,
    input  logic [2*OUT_WIDTH+1:0]   rom_data,
    output logic [OUT_WIDTH-1:0]     x_out,
    output logic [OUT_WIDTH-1:0]     y_out,
    output logic                     beam_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     frame_overrun
);
    localparam int IW = $clog2(ENTITY_COUNT + 1);
    localparam int CW = $clog2(MAX_POINTS);
`ifdef ENTITY_BLANK_MOVE_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    draw_state_t state, state_next;
    logic [OUT_WIDTH-1:0]    lx [ENTITY_COUNT];
    logic [OUT_WIDTH-1:0]    ly [ENTITY_COUNT];
    logic [ADDRESSWIDTH-1:0] ladr [ENTITY_COUNT];
    logic [ENTITY_COUNT-1:0] lspawn;
    logic [IW-1:0]           idx, sel;
    logic [CW-1:0]           cnt;
    logic                    found, last_q, blank_q, hs, end_sprite;
    logic [OUT_WIDTH-1:0]    xsum, ysum;

    assign hs         = out_valid && out_ready;
    assign end_sprite = last_q || cnt == CW'(MAX_POINTS - 1);

    // Descending scan so the lowest qualifying slot wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = ENTITY_COUNT - 1; i >= 0; i--) begin
            if (lspawn[i] && IW'(i) >= idx) begin
                found = 1'b1;
                sel   = IW'(i);
            end
        end
    end

    vec_point_sat #(.W(OUT_WIDTH)) u_sat_x (
        .base (lx[idx]),
        .off  (rom_data[OUT_WIDTH-1:0]),
        .sum  (xsum)
    );

    vec_point_sat #(.W(OUT_WIDTH)) u_sat_y (
        .base (ly[idx]),
        .off  (rom_data[2*OUT_WIDTH-1:OUT_WIDTH]),
        .sum  (ysum)
    );

    always_ff @(posedge clk) begin
        state <= !rst ? IDLE : state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = frame_start ? SELECT : IDLE;
            SELECT:  state_next = !found ? DONE : BLANK ? EMIT : ADDR;
            ADDR:    state_next = DATA;
            DATA:    state_next = EMIT;
            // A blank move always proceeds into its sprite's first ROM read.
            EMIT:    state_next = !hs ? EMIT : (!blank_q && end_sprite) ? SELECT : ADDR;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lx            <= '{default: '0};
            ly            <= '{default: '0};
            ladr          <= '{default: '0};
            lspawn        <= '0;
            idx           <= '0;
            cnt           <= '0;
            last_q        <= 1'b0;
            blank_q       <= 1'b0;
            rom_adr       <= '0;
            x_out         <= '0;
            y_out         <= '0;
            beam_en       <= 1'b0;
            out_valid     <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            busy          <= state_next != IDLE;
            frame_done    <= state_next == DONE;
            frame_overrun <= frame_start && state != IDLE;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        lx     <= x_ent;
                        ly     <= y_ent;
                        ladr   <= adr_ent;
                        lspawn <= spawn_ent;
                        idx    <= '0;
                    end
                end
                SELECT: begin
                    if (found) begin
                        idx     <= sel;
                        rom_adr <= ladr[sel];
                        cnt     <= '0;
                        if (BLANK) begin
                            x_out     <= lx[sel];
                            y_out     <= ly[sel];
                            beam_en   <= 1'b0;
                            out_valid <= 1'b1;
                            blank_q   <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    x_out     <= xsum;
                    y_out     <= ysum;
                    beam_en   <= rom_data[2*OUT_WIDTH];
                    last_q    <= rom_data[2*OUT_WIDTH+1];
                    out_valid <= 1'b1;
                end
                EMIT: begin
                    if (hs) begin
                        out_valid <= 1'b0;
                        blank_q   <= 1'b0;
                        if (!blank_q) begin
                            if (end_sprite) begin
                                idx <= idx + 1'b1;
                            end else begin
                                rom_adr <= rom_adr + 1'b1;
                                cnt     <= cnt + 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_entity_draw_sequencer.sv
// tb_entity_draw_sequencer: directed, scoreboard-based bench for entity_draw_sequencer.
// Expected points are queued as each frame is set up and compared on every output handshake.
module tb_entity_draw_sequencer;
    import vector_pkg::*;

`ifdef ENTITY_BLANK_MOVE_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif
    localparam int FIRST_LAT = BLANK ? 2 : 4;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       b;
    } pt_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_start = 1'b0;
    logic [7:0]  x_ent [3];
    logic [7:0]  y_ent [3];
    logic [2:0]  spawn_ent = '0;
    logic [15:0] adr_ent [3];
    logic [15:0] rom_adr;
    logic [17:0] rom_data = '0;
    logic [7:0]  x_out, y_out;
    logic        beam_en, out_valid, busy, frame_done, frame_overrun;
    logic        out_ready = 1'b0;

    logic [17:0] rom [65536];
    pt_t         exp_q [$];
    int          errors = 0;
    int          checks = 0;
    int          ncyc = 0, fs_cyc = 0, hs_cyc = 0, npts = 0, done_cnt = 0;
    bit          first_seen = 1'b1, pend = 1'b0;
    pt_t         held, got, e;

    entity_draw_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .x_ent         (x_ent),
        .y_ent         (y_ent),
        .spawn_ent     (spawn_ent),
        .adr_ent       (adr_ent),
        .rom_adr       (rom_adr),
        .rom_data      (rom_data),
        .x_out         (x_out),
        .y_out         (y_out),
        .beam_en       (beam_en),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_overrun (frame_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_adr];

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] w(input bit last, input bit beam, input logic [7:0] xo, input logic [7:0] yo);
        sprite_word_t s;
        s = '{last: last, beam: beam, yoff: yo, xoff: xo};
        return s;
    endfunction

    task automatic push(input logic [7:0] x, input logic [7:0] y, input logic b);
        exp_q.push_back('{x: x, y: y, b: b});
    endtask

    task automatic push_blank(input logic [7:0] x, input logic [7:0] y);
        if (BLANK) push(x, y, 1'b0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ent(input int i, input logic [7:0] x, input logic [7:0] y, input logic [15:0] a);
        x_ent[i]   = x;
        y_ent[i]   = y;
        adr_ent[i] = a;
    endtask

    task automatic start();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick(1);
            n++;
        end
        chk("frame_done_seen", done_cnt - d0, 1);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            tick(1);
            n++;
        end
        chk("valid_seen", out_valid, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rom_adr"}, rom_adr, 0);
        chk({tag, "_x_out"}, x_out, 0);
        chk({tag, "_y_out"}, y_out, 0);
        chk({tag, "_beam_en"}, beam_en, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_frame_overrun"}, frame_overrun, 0);
    endtask

    always @(negedge clk) begin
        ncyc++;
        if (!rst) begin
            pend       = 1'b0;
            first_seen = 1'b1;
        end else begin
            if (frame_start && !busy) begin
                fs_cyc     = ncyc;
                npts       = 0;
                first_seen = 1'b0;
            end
            got = '{x: x_out, y: y_out, b: beam_en};
            if (out_valid && !first_seen) begin
                chk("first_valid_latency", ncyc - fs_cyc, FIRST_LAT);
                first_seen = 1'b1;
            end
            if (pend) begin
                chk("held_valid", out_valid, 1);
                chk("held_point", got, held);
            end
            pend = out_valid && !out_ready;
            held = got;
            if (out_valid && out_ready) begin
                chk("point_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("point_x", got.x, e.x);
                    chk("point_y", got.y, e.y);
                    chk("point_beam", got.b, e.b);
                end
                hs_cyc = ncyc;
                npts++;
            end
            if (frame_done) begin
                done_cnt++;
                chk("done_latency", npts > 0 ? ncyc - hs_cyc : ncyc - fs_cyc, 2);
            end
        end
    end

    initial begin
        int d;
        foreach (rom[i]) rom[i] = '0;
        for (int i = 0; i < 3; i++) set_ent(i, 8'd0, 8'd0, 16'd0);
        rom[16'h0100] = w(1'b0, 1'b1, 8'd1, 8'd1);
        rom[16'h0101] = w(1'b0, 1'b0, 8'd2, 8'd3);
        rom[16'h0102] = w(1'b1, 1'b1, 8'd4, 8'd5);
        rom[16'h0200] = w(1'b1, 1'b1, 8'd10, 8'd3);
        rom[16'h0300] = w(1'b1, 1'b1, 8'd0, 8'd0);
        for (int i = 0; i < 64; i++) rom[16'(16'hFFF0 + i)] = w(1'b0, i[0], 8'(i), 8'(2 * i));

        tick(3);
        chk_reset_outputs("por");
        rst = 1'b1;
        tick(1);

        // reset while a point is held in EMIT
        set_ent(0, 8'd10, 8'd20, 16'h0100);
        spawn_ent = 3'b001;
        out_ready = 1'b0;
        start();
        wait_valid(10);
        rst = 1'b0;
        tick(1);
        chk_reset_outputs("mid_emit");
        rst = 1'b1;
        tick(1);

        // single sprite
        out_ready = 1'b1;
        push_blank(8'd10, 8'd20);
        push(8'd11, 8'd21, 1'b1);
        push(8'd12, 8'd23, 1'b0);
        push(8'd14, 8'd25, 1'b1);
        start();
        wait_done(50);
        chk("single_drained", exp_q.size(), 0);
        tick(2);

        // saturation with slots 0 and 1 skipped
        spawn_ent = 3'b100;
        set_ent(2, 8'd250, 8'd250, 16'h0200);
        push_blank(8'd250, 8'd250);
        push(8'd255, 8'd253, 1'b1);
        start();
        tick(1);
        chk("skip_rom_adr", rom_adr, 16'h0200);
        wait_done(50);
        chk("sat_drained", exp_q.size(), 0);
        tick(2);

        // backpressure and overrun
        spawn_ent = 3'b001;
        out_ready = 1'b0;
        push_blank(8'd10, 8'd20);
        push(8'd11, 8'd21, 1'b1);
        push(8'd12, 8'd23, 1'b0);
        push(8'd14, 8'd25, 1'b1);
        start();
        wait_valid(10);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        chk("overrun_pulse", frame_overrun, 1);
        tick(1);
        chk("overrun_single", frame_overrun, 0);
        tick(3);
        out_ready = 1'b1;
        wait_done(100);
        chk("bp_drained", exp_q.size(), 0);
        d = done_cnt;
        tick(10);
        chk("no_restart_done", done_cnt - d, 0);
        chk("no_restart_busy", busy, 0);

        // empty frame
        spawn_ent = 3'b000;
        start();
        wait_done(20);
        chk("empty_busy_low", busy, 0);
        tick(2);

        // runaway sprite (no last flag, wrapping address) followed by slot 2
        spawn_ent = 3'b110;
        set_ent(1, 8'd0, 8'd0, 16'hFFF0);
        set_ent(2, 8'd5, 8'd5, 16'h0300);
        push_blank(8'd0, 8'd0);
        for (int i = 0; i < 64; i++) push(8'(i), 8'(2 * i), i[0]);
        push_blank(8'd5, 8'd5);
        push(8'd5, 8'd5, 1'b1);
        start();
        wait_done(1000);
        chk("runaway_drained", exp_q.size(), 0);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
